// File: rtl/alu_pkg.sv
// Shared widths, alu opcode encoding and status-flag layout for the alu and execute unit.
package alu_pkg;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned ADDR_W  = 5;
    localparam int unsigned NREGS   = 2 ** ADDR_W;
    localparam int unsigned ALUC_W  = 4;
    localparam int unsigned FLAG_W  = 4;
    localparam int unsigned SHAMT_W = $clog2(DATA_W);

    localparam int unsigned FLAG_ZERO  = 0;
    localparam int unsigned FLAG_CARRY = 1;
    localparam int unsigned FLAG_NEG   = 2;
    localparam int unsigned FLAG_OVF   = 3;

    localparam logic [ALUC_W-1:0] ALUC_ADDU = 4'b0000;
    localparam logic [ALUC_W-1:0] ALUC_SUBU = 4'b0001;
    localparam logic [ALUC_W-1:0] ALUC_ADD  = 4'b0010;
    localparam logic [ALUC_W-1:0] ALUC_SUB  = 4'b0011;
    localparam logic [ALUC_W-1:0] ALUC_AND  = 4'b0100;
    localparam logic [ALUC_W-1:0] ALUC_OR   = 4'b0101;
    localparam logic [ALUC_W-1:0] ALUC_XOR  = 4'b0110;
    localparam logic [ALUC_W-1:0] ALUC_NOR  = 4'b0111;
    localparam logic [ALUC_W-1:0] ALUC_LUI  = 4'b1000;
    localparam logic [ALUC_W-1:0] ALUC_SLTU = 4'b1010;
    localparam logic [ALUC_W-1:0] ALUC_SLT  = 4'b1011;
    localparam logic [ALUC_W-1:0] ALUC_SRA  = 4'b1100;
    localparam logic [ALUC_W-1:0] ALUC_SRL  = 4'b1101;
    localparam logic [ALUC_W-1:0] ALUC_SLL  = 4'b1110;

    // Field order places each flag at its FLAG_* bit index.
    typedef struct packed {
        logic overflow;
        logic negative;
        logic carry;
        logic zero;
    } alu_flags_t;

endpackage

// File: rtl/alu_exec_unit_alu.sv
// Combinational alu: result plus {overflow, negative, carry, zero}; shifts move b by a[4:0].
module alu
    import alu_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [ALUC_W-1:0] aluc,
    output logic [DATA_W-1:0] r,
    output logic              zero,
    output logic              carry,
    output logic              negative,
    output logic              overflow
);

    logic [DATA_W:0]      sum_c;
    logic [DATA_W:0]      dif_c;
    logic [SHAMT_W-1:0]   shamt_c;

    always_comb begin
        sum_c    = {1'b0, a} + {1'b0, b};
        dif_c    = {1'b0, a} - {1'b0, b};
        shamt_c  = a[SHAMT_W-1:0];
        r        = '0;
        carry    = 1'b0;
        overflow = 1'b0;
        case (aluc)
            ALUC_ADDU: begin
                r     = sum_c[DATA_W-1:0];
                carry = sum_c[DATA_W];
            end
            ALUC_ADD: begin
                r        = sum_c[DATA_W-1:0];
                carry    = sum_c[DATA_W];
                overflow = (a[DATA_W-1] == b[DATA_W-1]) && (r[DATA_W-1] != a[DATA_W-1]);
            end
            // carry on subtract is the unsigned borrow
            ALUC_SUBU: begin
                r     = dif_c[DATA_W-1:0];
                carry = dif_c[DATA_W];
            end
            ALUC_SUB: begin
                r        = dif_c[DATA_W-1:0];
                carry    = dif_c[DATA_W];
                overflow = (a[DATA_W-1] != b[DATA_W-1]) && (r[DATA_W-1] != a[DATA_W-1]);
            end
            ALUC_AND:  r = a & b;
            ALUC_OR:   r = a | b;
            ALUC_XOR:  r = a ^ b;
            ALUC_NOR:  r = ~(a | b);
            ALUC_LUI:  r = {b[DATA_W/2-1:0], (DATA_W/2)'(0)};
            ALUC_SLTU: r = DATA_W'(a < b);
            ALUC_SLT:  r = DATA_W'($signed(a) < $signed(b));
            ALUC_SRA:  r = DATA_W'($signed(b) >>> shamt_c);
            ALUC_SRL:  r = b >> shamt_c;
            ALUC_SLL:  r = b << shamt_c;
            default:   r = '0;
        endcase
        zero     = (r == '0);
        negative = r[DATA_W-1];
    end

endmodule

// File: rtl/alu_exec_unit.sv
// Two-stage execute unit: issue reads the register file (with bypass of the completing op),
// execute drives the alu, writeback updates the register file, status flags and wb_* outputs.
module alu_exec_unit
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ALUC_W-1:0] req_aluc,
    input  logic [ADDR_W-1:0] req_rs,
    input  logic [ADDR_W-1:0] req_rt,
    input  logic [ADDR_W-1:0] req_rd,
    input  logic              req_imm_en,
    input  logic [DATA_W-1:0] req_imm,
    input  logic              ld_en,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    output logic              wb_valid,
    output logic [ADDR_W-1:0] wb_rd,
    output logic [DATA_W-1:0] wb_data,
    output logic [FLAG_W-1:0] flags,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    logic [DATA_W-1:0] regs_q [NREGS];

    logic              ex_valid_q, ex_valid_d;
    logic [ALUC_W-1:0] ex_aluc_q,  ex_aluc_d;
    logic [ADDR_W-1:0] ex_rd_q,    ex_rd_d;
    logic [DATA_W-1:0] ex_a_q,     ex_a_d;
    logic [DATA_W-1:0] ex_b_q,     ex_b_d;

    logic              wb_valid_q, wb_valid_d;
    logic [ADDR_W-1:0] wb_rd_q,    wb_rd_d;
    logic [DATA_W-1:0] wb_data_q,  wb_data_d;
    alu_flags_t        flags_q,    flags_d;

    logic [DATA_W-1:0] alu_r_c;
    alu_flags_t        alu_flags_c;
    logic              issue_c;
    logic              wb_we_c;
    logic [DATA_W-1:0] rs_val_c;
    logic [DATA_W-1:0] rt_val_c;

    alu u_alu (
        .a        (ex_a_q),
        .b        (ex_b_q),
        .aluc     (ex_aluc_q),
        .r        (alu_r_c),
        .zero     (alu_flags_c.zero),
        .carry    (alu_flags_c.carry),
        .negative (alu_flags_c.negative),
        .overflow (alu_flags_c.overflow)
    );

    assign req_ready = ~ld_en;
    assign issue_c   = req_valid & req_ready;
    assign wb_we_c   = ex_valid_q && (ex_rd_q != '0);

    // Source read: r0 is zero, the op retiring at this edge is forwarded, else the register file.
    always_comb begin
        rs_val_c = regs_q[req_rs];
        rt_val_c = regs_q[req_rt];
        if (req_rs == '0) begin
            rs_val_c = '0;
        end else if (ex_valid_q && (ex_rd_q == req_rs)) begin
            rs_val_c = alu_r_c;
        end
        if (req_rt == '0) begin
            rt_val_c = '0;
        end else if (ex_valid_q && (ex_rd_q == req_rt)) begin
            rt_val_c = alu_r_c;
        end
    end

    always_comb begin
        ex_valid_d = 1'b0;
        ex_aluc_d  = ex_aluc_q;
        ex_rd_d    = ex_rd_q;
        ex_a_d     = ex_a_q;
        ex_b_d     = ex_b_q;
        wb_valid_d = ex_valid_q;
        wb_rd_d    = wb_rd_q;
        wb_data_d  = wb_data_q;
        flags_d    = flags_q;
        if (issue_c) begin
            ex_valid_d = 1'b1;
            ex_aluc_d  = req_aluc;
            ex_rd_d    = req_rd;
            ex_a_d     = rs_val_c;
            ex_b_d     = req_imm_en ? req_imm : rt_val_c;
        end
        if (ex_valid_q) begin
            wb_rd_d   = ex_rd_q;
            wb_data_d = alu_r_c;
            flags_d   = alu_flags_c;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_q <= 1'b0;
            ex_aluc_q  <= '0;
            ex_rd_q    <= '0;
            ex_a_q     <= '0;
            ex_b_q     <= '0;
            wb_valid_q <= 1'b0;
            wb_rd_q    <= '0;
            wb_data_q  <= '0;
            flags_q    <= '0;
        end else begin
            ex_valid_q <= ex_valid_d;
            ex_aluc_q  <= ex_aluc_d;
            ex_rd_q    <= ex_rd_d;
            ex_a_q     <= ex_a_d;
            ex_b_q     <= ex_b_d;
            wb_valid_q <= wb_valid_d;
            wb_rd_q    <= wb_rd_d;
            wb_data_q  <= wb_data_d;
            flags_q    <= flags_d;
        end
    end

    // Register file; r0 is never written. Writeback beats a load to the same address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 1; i < NREGS; i++) begin
                if (wb_we_c && (ex_rd_q == ADDR_W'(i))) begin
                    regs_q[i] <= alu_r_c;
                end else if (ld_en && (ld_addr == ADDR_W'(i))) begin
                    regs_q[i] <= ld_data;
                end
            end
        end
    end

    assign wb_valid = wb_valid_q;
    assign wb_rd    = wb_rd_q;
    assign wb_data  = wb_data_q;
    assign flags    = flags_q;
    assign dbg_data = (dbg_addr == '0) ? '0 : regs_q[dbg_addr];

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: in-order reference model feeding a writeback scoreboard.
module tb_alu_exec_unit;
    import alu_pkg::*;

    logic              clk;
    logic              rst_n;
    logic              req_valid;
    logic              req_ready;
    logic [3:0]        req_aluc;
    logic [4:0]        req_rs, req_rt, req_rd;
    logic              req_imm_en;
    logic [31:0]       req_imm;
    logic              ld_en;
    logic [4:0]        ld_addr;
    logic [31:0]       ld_data;
    logic              wb_valid;
    logic [4:0]        wb_rd;
    logic [31:0]       wb_data;
    logic [3:0]        flags;
    logic [4:0]        dbg_addr;
    logic [31:0]       dbg_data;

    alu_exec_unit dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_aluc   (req_aluc),
        .req_rs     (req_rs),
        .req_rt     (req_rt),
        .req_rd     (req_rd),
        .req_imm_en (req_imm_en),
        .req_imm    (req_imm),
        .ld_en      (ld_en),
        .ld_addr    (ld_addr),
        .ld_data    (ld_data),
        .wb_valid   (wb_valid),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data),
        .flags      (flags),
        .dbg_addr   (dbg_addr),
        .dbg_data   (dbg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        logic [3:0]  flg;
    } exp_t;

    exp_t        sb_q [$];
    logic [31:0] model_regs [32];
    logic [3:0]  model_flags;
    bit          prev_acc;
    logic [4:0]  prev_rd;
    int          n_checks;
    int          n_fail;

    logic [3:0] op_tbl [14] = '{ALUC_ADDU, ALUC_SUBU, ALUC_ADD, ALUC_SUB, ALUC_AND, ALUC_OR,
                                ALUC_XOR, ALUC_NOR, ALUC_LUI, ALUC_SLTU, ALUC_SLT,
                                ALUC_SRA, ALUC_SRL, ALUC_SLL};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic void alu_ref(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] r, output logic [3:0] f);
        longint sa, sb;
        logic   c, v;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        c  = 1'b0;
        v  = 1'b0;
        case (op)
            ALUC_ADDU, ALUC_ADD: begin
                r = a + b;
                c = (r < a);
                if (op == ALUC_ADD) v = ((sa + sb) != longint'($signed(r)));
            end
            ALUC_SUBU, ALUC_SUB: begin
                r = a - b;
                c = (a < b);
                if (op == ALUC_SUB) v = ((sa - sb) != longint'($signed(r)));
            end
            ALUC_AND:  r = a & b;
            ALUC_OR:   r = a | b;
            ALUC_XOR:  r = a ^ b;
            ALUC_NOR:  r = ~(a | b);
            ALUC_LUI:  r = {b[15:0], 16'h0000};
            ALUC_SLTU: r = (a < b) ? 32'd1 : 32'd0;
            ALUC_SLT:  r = (sa < sb) ? 32'd1 : 32'd0;
            ALUC_SRA:  r = 32'(sb >>> a[4:0]);
            ALUC_SRL:  r = b >> a[4:0];
            ALUC_SLL:  r = b << a[4:0];
            default:   r = 32'd0;
        endcase
        f = {v, r[31], c, (r == 32'd0)};
    endfunction

    function automatic logic [31:0] rd_model(input logic [4:0] x);
        return (x == 5'd0) ? 32'd0 : model_regs[x];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) model_regs[i] = 32'd0;
        sb_q.delete();
        model_flags = 4'd0;
        prev_acc    = 1'b0;
        prev_rd     = 5'd0;
    endtask

    task automatic drive_req(input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
                             input logic [4:0] rd, input logic imm_en, input logic [31:0] imm);
        req_valid  = 1'b1;
        req_aluc   = op;
        req_rs     = rs;
        req_rt     = rt;
        req_rd     = rd;
        req_imm_en = imm_en;
        req_imm    = imm;
    endtask

    task automatic idle();
        req_valid = 1'b0;
        ld_en     = 1'b0;
    endtask

    // One clock: model the accept/load at this edge, then check writeback and flags after it.
    task automatic step();
        bit          acc;
        logic [4:0]  acc_rd;
        logic [31:0] a, b, r;
        logic [3:0]  f;
        exp_t        e;
        #1;
        check_eq("req_ready", 32'(req_ready), 32'(!ld_en));
        acc    = req_valid && req_ready;
        acc_rd = req_rd;
        if (acc) begin
            a = rd_model(req_rs);
            b = req_imm_en ? req_imm : rd_model(req_rt);
            alu_ref(req_aluc, a, b, r, f);
            e.rd   = req_rd;
            e.data = r;
            e.flg  = f;
            sb_q.push_back(e);
            if (req_rd != 5'd0) model_regs[req_rd] = r;
        end
        if (ld_en && ld_addr != 5'd0 && !(prev_acc && prev_rd == ld_addr))
            model_regs[ld_addr] = ld_data;
        @(posedge clk);
        #1;
        check_eq("wb_valid", 32'(wb_valid), 32'(prev_acc));
        if (wb_valid) begin
            if (sb_q.size() == 0) begin
                check_eq("sb_underflow", 32'(sb_q.size()), 32'd1);
            end else begin
                e = sb_q.pop_front();
                check_eq("wb_rd", 32'(wb_rd), 32'(e.rd));
                check_eq("wb_data", wb_data, e.data);
                model_flags = e.flg;
            end
        end
        check_eq("flags", 32'(flags), 32'(model_flags));
        prev_acc = acc;
        prev_rd  = acc_rd;
    endtask

    task automatic load(input logic [4:0] addr, input logic [31:0] data);
        ld_en   = 1'b1;
        ld_addr = addr;
        ld_data = data;
        step();
        ld_en   = 1'b0;
    endtask

    task automatic check_dbg(input string tag, input logic [4:0] addr, input logic [31:0] exp);
        dbg_addr = addr;
        #1;
        check_eq(tag, dbg_data, exp);
    endtask

    initial begin
        bit pend;
        n_checks = 0;
        n_fail   = 0;
        model_reset();
        rst_n = 1'b0;
        req_valid = 1'b0; req_aluc = 4'd0; req_rs = 5'd0; req_rt = 5'd0; req_rd = 5'd0;
        req_imm_en = 1'b0; req_imm = 32'd0;
        ld_en = 1'b0; ld_addr = 5'd0; ld_data = 32'd0; dbg_addr = 5'd0;

        #12;
        check_eq("rst_wb_valid", 32'(wb_valid), 32'd0);
        check_eq("rst_wb_rd", 32'(wb_rd), 32'd0);
        check_eq("rst_wb_data", wb_data, 32'd0);
        check_eq("rst_flags", 32'(flags), 32'd0);
        check_eq("rst_req_ready", 32'(req_ready), 32'd1);
        rst_n = 1'b1;

        // Reset while an op is in flight: it must never retire.
        load(5'd1, 32'd32);
        load(5'd2, 32'd64);
        drive_req(ALUC_ADD, 5'd1, 5'd2, 5'd3, 1'b0, 32'd0);
        step();
        idle();
        #1;
        rst_n = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        check_eq("rst_mid_wb_valid", 32'(wb_valid), 32'd0);
        check_eq("rst_mid_flags", 32'(flags), 32'd0);
        check_dbg("rst_mid_r3", 5'd3, 32'd0);
        check_dbg("rst_mid_r1", 5'd1, 32'd0);
        rst_n = 1'b1;

        // Basic add.
        load(5'd1, 32'd32);
        load(5'd2, 32'd64);
        drive_req(ALUC_ADD, 5'd1, 5'd2, 5'd3, 1'b0, 32'd0);
        step();
        idle();
        step();
        check_eq("basic_wb_data", wb_data, 32'd96);
        check_eq("basic_zero", 32'(flags[FLAG_ZERO]), 32'd0);
        check_dbg("basic_r3", 5'd3, 32'd96);

        // Back-to-back dependency needs the bypass; r0 must not be forwarded.
        drive_req(ALUC_ADD, 5'd1, 5'd2, 5'd3, 1'b0, 32'd0);
        step();
        drive_req(ALUC_ADD, 5'd3, 5'd3, 5'd4, 1'b0, 32'd0);
        step();
        idle();
        step();
        check_eq("bypass_wb_data", wb_data, 32'd192);
        check_dbg("bypass_r4", 5'd4, 32'd192);
        drive_req(ALUC_ADD, 5'd1, 5'd2, 5'd0, 1'b0, 32'd0);
        step();
        drive_req(ALUC_ADD, 5'd0, 5'd0, 5'd4, 1'b0, 32'd0);
        step();
        idle();
        step();
        check_eq("r0_nofwd_wb_data", wb_data, 32'd0);
        check_dbg("r0_nofwd_r4", 5'd4, 32'd0);

        // Signed overflow into r0.
        load(5'd5, 32'h7FFF_FFFF);
        drive_req(ALUC_ADD, 5'd5, 5'd0, 5'd0, 1'b1, 32'd1);
        step();
        idle();
        step();
        check_eq("ovf_wb_data", wb_data, 32'h8000_0000);
        check_eq("ovf_flags", 32'(flags), 32'b1100);
        check_dbg("ovf_r0", 5'd0, 32'd0);

        // Load stalls a pending request for one cycle.
        drive_req(ALUC_ADDU, 5'd6, 5'd0, 5'd8, 1'b0, 32'd0);
        ld_en = 1'b1; ld_addr = 5'd6; ld_data = 32'd15;
        #1;
        check_eq("stall_req_ready", 32'(req_ready), 32'd0);
        step();
        ld_en = 1'b0;
        step();
        idle();
        step();
        check_eq("stall_wb_data", wb_data, 32'd15);
        check_dbg("stall_r8", 5'd8, 32'd15);

        // Writeback and load to the same register on one edge; then different registers.
        drive_req(ALUC_SUB, 5'd1, 5'd1, 5'd7, 1'b0, 32'd0);
        step();
        idle();
        load(5'd7, 32'h55);
        check_dbg("collide_r7", 5'd7, 32'd0);
        check_eq("collide_flags", 32'(flags), 32'b0001);
        drive_req(ALUC_ADD, 5'd1, 5'd2, 5'd9, 1'b0, 32'd0);
        step();
        idle();
        load(5'd10, 32'h77);
        check_dbg("split_r9", 5'd9, 32'd96);
        check_dbg("split_r10", 5'd10, 32'h77);

        // Random traffic on a small register window to stress bypass and load collisions.
        pend = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!pend) begin
                if ($urandom_range(3) != 0) begin
                    drive_req(op_tbl[$urandom_range(13)], 5'($urandom_range(7)),
                              5'($urandom_range(7)), 5'($urandom_range(7)),
                              1'($urandom_range(1)), $urandom());
                    pend = 1'b1;
                end else begin
                    req_valid = 1'b0;
                end
            end
            ld_en   = ($urandom_range(4) == 0);
            ld_addr = 5'($urandom_range(7));
            ld_data = $urandom();
            step();
            if (prev_acc) pend = 1'b0;
            dbg_addr = 5'($urandom_range(7));
            if (!(prev_acc && prev_rd == dbg_addr && prev_rd != 5'd0))
                check_dbg("rand_dbg", dbg_addr, rd_model(dbg_addr));
        end
        idle();
        step();
        step();
        check_eq("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
